// File: rtl/dcache_sram_arb_if.sv
// rtl/dcache_sram_arb_if.sv - requester-side bundle of the dcache SRAM arbiter
interface dcache_sram_arb_if #(
    parameter int NR_PORTS   = 4,
    parameter int WAYS       = 8,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 512,
    parameter int BE_WIDTH   = 64
);
    logic [NR_PORTS*WAYS-1:0]       req;
    logic [NR_PORTS*ADDR_WIDTH-1:0] addr;
    logic [NR_PORTS*DATA_WIDTH-1:0] wdata;
    logic [NR_PORTS-1:0]            we;
    logic [NR_PORTS*BE_WIDTH-1:0]   be;
    logic [NR_PORTS-1:0]            gnt;
    logic [NR_PORTS-1:0]            rvalid;
    logic [WAYS*DATA_WIDTH-1:0]     rdata;

    modport master (output req, addr, wdata, we, be, input gnt, rvalid, rdata);
    modport slave  (input req, addr, wdata, we, be, output gnt, rvalid, rdata);
endinterface

// File: rtl/dcache_sram_arb.sv
// rtl/dcache_sram_arb.sv - dcache SRAM port arbiter: fixed-priority port 0, round-robin 1..N-1, starvation override
// Optional perf counters enabled by DCACHE_ARB_PERF_EN.
module dcache_sram_arb #(
    parameter int NR_PORTS     = 4,
    parameter int WAYS         = 8,
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 512,
    parameter int BE_WIDTH     = 64,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    dcache_sram_arb_if.slave            bus,
    output logic [WAYS-1:0]             req_o,
    output logic [ADDR_WIDTH-1:0]       addr_o,
    output logic [DATA_WIDTH-1:0]       wdata_o,
    output logic                        we_o,
    output logic [BE_WIDTH-1:0]         be_o,
    input  logic [WAYS*DATA_WIDTH-1:0]  rdata_i,
    output logic [31:0]                 conflict_cnt_o,
    output logic                        starve_evt_o
);
    localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam int PTR_W = $clog2(NR_PORTS);

    logic [NR_PORTS-1:0] req_any;
    logic [NR_PORTS-1:0] gnt;
    logic [NR_PORTS-1:0] rvalid_q;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    sel;
    logic                gnt_vld;
    logic                starve_hit;
    logic [AGE_W-1:0]    age [1:NR_PORTS-1];
    int                  rr_idx;

    always_comb begin
        for (int p = 0; p < NR_PORTS; p++)
            req_any[p] = |bus.req[p*WAYS +: WAYS];
    end

    // Descending scans so the lowest qualifying index is the last writer and wins.
    always_comb begin
        starve_hit = 1'b0;
        gnt_vld    = 1'b0;
        sel        = '0;
        rr_idx     = 0;
        for (int p = NR_PORTS - 1; p >= 1; p--) begin
            if (req_any[p] && age[p] == AGE_W'(STARVE_LIMIT)) begin
                starve_hit = 1'b1;
                sel        = PTR_W'(p);
            end
        end
        if (starve_hit) begin
            gnt_vld = 1'b1;
        end else if (req_any[0]) begin
            gnt_vld = 1'b1;
            sel     = '0;
        end else begin
            for (int i = NR_PORTS - 2; i >= 0; i--) begin
                rr_idx = int'(rr_ptr) + i;
                if (rr_idx >= NR_PORTS)
                    rr_idx = rr_idx - (NR_PORTS - 1);
                if (req_any[rr_idx]) begin
                    gnt_vld = 1'b1;
                    sel     = PTR_W'(rr_idx);
                end
            end
        end
    end

    always_comb begin
        gnt     = '0;
        req_o   = '0;
        addr_o  = '0;
        wdata_o = '0;
        we_o    = 1'b0;
        be_o    = '0;
        if (gnt_vld) begin
            gnt[sel] = 1'b1;
            req_o    = bus.req[sel*WAYS +: WAYS];
            addr_o   = bus.addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
            wdata_o  = bus.wdata[sel*DATA_WIDTH +: DATA_WIDTH];
            we_o     = bus.we[sel];
            be_o     = bus.be[sel*BE_WIDTH +: BE_WIDTH];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= '0;
            rr_ptr   <= PTR_W'(1);
            for (int p = 1; p < NR_PORTS; p++)
                age[p] <= '0;
        end else begin
            rvalid_q <= gnt & ~bus.we;
            if (gnt_vld && sel != '0)
                rr_ptr <= (sel == PTR_W'(NR_PORTS - 1)) ? PTR_W'(1) : sel + 1'b1;
            for (int p = 1; p < NR_PORTS; p++) begin
                if (!req_any[p] || gnt[p])
                    age[p] <= '0;
                else if (age[p] != AGE_W'(STARVE_LIMIT))
                    age[p] <= age[p] + 1'b1;
            end
        end
    end

    assign bus.gnt    = gnt;
    assign bus.rvalid = rvalid_q;
    assign bus.rdata  = rdata_i;

`ifdef DCACHE_ARB_PERF_EN
    logic [31:0] conflict_q;
    logic        starve_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_q <= '0;
            starve_q   <= 1'b0;
        end else begin
            if ($countones(req_any) > 1)
                conflict_q <= conflict_q + 32'd1;
            starve_q <= starve_hit;
        end
    end

    assign conflict_cnt_o = conflict_q;
    assign starve_evt_o   = starve_q;
`else
    assign conflict_cnt_o = '0;
    assign starve_evt_o   = 1'b0;
`endif
endmodule

// File: tb/tb_dcache_sram_arb.sv
// tb/tb_dcache_sram_arb.sv - directed self-checking bench for dcache_sram_arb
module tb_dcache_sram_arb;
`ifdef DCACHE_ARB_PERF_EN
    localparam logic PERF = 1'b1;
`else
    localparam logic PERF = 1'b0;
`endif
    localparam logic [63:0] RD_PAT = 64'hDEAD_BEEF_0123_4567;

    logic         clk;
    logic         rst_n;
    logic [7:0]   req_o;
    logic [11:0]  addr_o;
    logic [511:0] wdata_o;
    logic         we_o;
    logic [63:0]  be_o;
    logic [4095:0] sram_rdata;
    logic [31:0]  conflict_cnt;
    logic         starve_evt;
    int           vectors;
    int           miscompares;

    dcache_sram_arb_if bus ();

    dcache_sram_arb dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .bus            (bus.slave),
        .req_o          (req_o),
        .addr_o         (addr_o),
        .wdata_o        (wdata_o),
        .we_o           (we_o),
        .be_o           (be_o),
        .rdata_i        (sram_rdata),
        .conflict_cnt_o (conflict_cnt),
        .starve_evt_o   (starve_evt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input int p, input logic [7:0] way, input logic [11:0] a, input logic w);
        bus.req[p*8 +: 8]       = way;
        bus.addr[p*12 +: 12]    = a;
        bus.we[p]               = w;
        bus.wdata[p*512 +: 512] = {8{64'hC0DE_0000_0000_0000 | 64'(p)}};
        bus.be[p*64 +: 64]      = '1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.req     = '0;
        bus.addr    = '0;
        bus.wdata   = '0;
        bus.we      = '0;
        bus.be      = '0;
        sram_rdata  = {64{RD_PAT}};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt", 64'(bus.gnt), 64'h0);
        chk("rst_rvalid", 64'(bus.rvalid), 64'h0);
        chk("rst_req_o", 64'(req_o), 64'h0);
        chk("rst_conflict", 64'(conflict_cnt), 64'h0);
        chk("rst_starve", 64'(starve_evt), 64'h0);
        next_cycle();
        rst_n = 1'b1;

        // Port 0 beats port 2; port 2 follows next cycle
        set_port(0, 8'h01, 12'h010, 1'b0);
        set_port(2, 8'hFF, 12'h010, 1'b0);
        @(negedge clk);
        chk("p0_gnt", 64'(bus.gnt), 64'h1);
        chk("p0_req_o", 64'(req_o), 64'h01);
        chk("p0_addr_o", 64'(addr_o), 64'h010);
        chk("p0_we_o", 64'(we_o), 64'h0);
        chk("p0_rvalid_early", 64'(bus.rvalid), 64'h0);
        next_cycle();
        set_port(0, 8'h00, 12'h000, 1'b0);
        @(negedge clk);
        chk("p0_rvalid", 64'(bus.rvalid), 64'h1);
        chk("rdata_lo", bus.rdata[63:0], RD_PAT);
        chk("rdata_hi", bus.rdata[4095:4032], RD_PAT);
        chk("p2_gnt", 64'(bus.gnt), 64'h4);
        chk("p2_req_o", 64'(req_o), 64'hFF);
        chk("conflict_one", 64'(conflict_cnt), PERF ? 64'h1 : 64'h0);
        next_cycle();
        set_port(2, 8'h00, 12'h000, 1'b0);
        @(negedge clk);
        chk("p2_rvalid", 64'(bus.rvalid), 64'h4);
        chk("idle_gnt", 64'(bus.gnt), 64'h0);
        chk("idle_addr_o", 64'(addr_o), 64'h0);
        chk("idle_we_o", 64'(we_o), 64'h0);

        // Reset pulse restores rr_ptr to 1
        next_cycle();
        rst_n = 1'b0;
        @(negedge clk);
        chk("pulse_rvalid", 64'(bus.rvalid), 64'h0);
        next_cycle();
        rst_n = 1'b1;

        // Round-robin among ports 1..3
        for (int p = 1; p <= 3; p++)
            set_port(p, 8'h0F, 12'h100 + 12'(p), 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rr_gnt", 64'(bus.gnt), 64'(1 << (1 + i % 3)));
            chk("rr_addr_o", 64'(addr_o), 64'h100 + 64'(1 + i % 3));
            chk("rr_rvalid", 64'(bus.rvalid), (i == 0) ? 64'h0 : 64'(1 << (1 + (i - 1) % 3)));
            next_cycle();
        end
        for (int p = 1; p <= 3; p++)
            set_port(p, 8'h00, 12'h000, 1'b0);
        @(negedge clk);
        chk("rr_rvalid_last", 64'(bus.rvalid), 64'h8);
        chk("rr_idle_gnt", 64'(bus.gnt), 64'h0);

        // Starvation override: port 3 wins on the 9th cycle against port 0
        next_cycle();
        set_port(0, 8'h01, 12'h020, 1'b0);
        set_port(3, 8'h02, 12'h030, 1'b0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            chk("starve_gnt", 64'(bus.gnt), (k == 9) ? 64'h8 : 64'h1);
            chk("starve_evt_early", 64'(starve_evt), 64'h0);
            next_cycle();
            if (k == 9)
                set_port(3, 8'h00, 12'h000, 1'b0);
        end
        @(negedge clk);
        chk("starve_evt_pulse", 64'(starve_evt), PERF ? 64'h1 : 64'h0);
        chk("starve_rvalid", 64'(bus.rvalid), 64'h8);
        chk("after_starve_gnt", 64'(bus.gnt), 64'h1);
        next_cycle();
        @(negedge clk);
        chk("starve_evt_clear", 64'(starve_evt), 64'h0);
        chk("p0_rvalid_again", 64'(bus.rvalid), 64'h1);
        next_cycle();
        set_port(0, 8'h00, 12'h000, 1'b0);
        @(negedge clk);
        chk("drain_gnt", 64'(bus.gnt), 64'h0);
        next_cycle();

        // Write from port 1: same-cycle SRAM strobes, no rvalid
        set_port(1, 8'h04, 12'h02A, 1'b1);
        @(negedge clk);
        chk("wr_gnt", 64'(bus.gnt), 64'h2);
        chk("wr_req_o", 64'(req_o), 64'h04);
        chk("wr_we_o", 64'(we_o), 64'h1);
        chk("wr_be_o", be_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("wr_addr_o", 64'(addr_o), 64'h02A);
        chk("wr_wdata_o", wdata_o[63:0], 64'hC0DE_0000_0000_0001);
        chk("wr_rvalid_pre", 64'(bus.rvalid), 64'h0);
        next_cycle();
        set_port(1, 8'h00, 12'h000, 1'b0);
        @(negedge clk);
        chk("wr_rvalid", 64'(bus.rvalid), 64'h0);
        next_cycle();

        // Reset during an outstanding read response
        set_port(2, 8'h01, 12'h055, 1'b0);
        @(negedge clk);
        chk("mid_gnt", 64'(bus.gnt), 64'h4);
        @(posedge clk);
        #1;
        set_port(2, 8'h00, 12'h000, 1'b0);
        chk("mid_rvalid", 64'(bus.rvalid), 64'h4);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid", 64'(bus.rvalid), 64'h0);
        chk("mid_rst_conflict", 64'(conflict_cnt), 64'h0);
        chk("mid_rst_starve", 64'(starve_evt), 64'h0);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("post_rst_rvalid", 64'(bus.rvalid), 64'h0);
            chk("post_rst_gnt", 64'(bus.gnt), 64'h0);
            next_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
